// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one-outstanding imem requests, buffers words in a QDEPTH queue.
// Latency: ack at cycle N -> ifid_valid at N+1; zero-wait memory sustains one instruction per cycle.
// Backpressure: stall holds the queue head; no request launches unless a slot is free after this cycle's pop.
// Optional FETCH_BTFN_EN: static backward-taken prediction for negative-offset B-type branches.
module fetch_stage #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic            ifid_pred_taken
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

    state_t          state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] kill_addr;   // address of the abandoned request still owed an ack
    logic            inflight;    // a request was raised in an earlier cycle and not yet acked

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PC_W-1:0]  q_pc    [QDEPTH];
    logic [31:0]      q_instr [QDEPTH];

    logic             pop;
    logic             push;
    logic [CNT_W-1:0] cnt_after_pop;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  next_pc;

    assign ifid_valid    = (count != '0);
    assign pop           = ifid_valid && !stall;
    assign cnt_after_pop = count - CNT_W'(pop);
    assign push          = (state == REQ) && imem_req && imem_ack && !redirect_valid;
    assign seq_pc        = fetch_pc + PC_W'(4);

    // In KILL the memory still owns the old address; otherwise the PC register is the address
    assign imem_addr  = (state == KILL) ? kill_addr : fetch_pc;
    assign ifid_instr = q_instr[rd_ptr];
    assign ifid_pc    = q_pc[rd_ptr];

`ifdef FETCH_BTFN_EN
    logic        pred_taken;
    logic [12:0] br_off;
    logic        q_pred [QDEPTH];

    assign br_off     = {imem_rdata[31], imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    assign pred_taken = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
    assign next_pc    = pred_taken ? fetch_pc + {{(PC_W-13){br_off[12]}}, br_off} : seq_pc;
    assign ifid_pred_taken = q_pred[rd_ptr];

    // Prediction bit travels alongside the queue entry it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) q_pred[i] <= 1'b0;
        end else if (push) begin
            q_pred[wr_ptr] <= pred_taken;
        end
    end
`else
    assign next_pc         = seq_pc;
    assign ifid_pred_taken = 1'b0;
`endif

    // Request stays up while one is owed an ack, else only if a slot is free after the pop
    always_comb begin
        imem_req = 1'b0;
        case (state)
            REQ:     imem_req = inflight || (cnt_after_pop < CNT_FULL);
            KILL:    imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    // Fetch control: PC advance, redirect capture and killing of an abandoned request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            kill_addr <= RESET_PC;
            inflight  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        inflight <= 1'b0;
                        if (imem_req && !imem_ack) begin
                            state     <= KILL;
                            kill_addr <= fetch_pc;
                        end
                    end else if (imem_req) begin
                        if (imem_ack) begin
                            fetch_pc <= next_pc;
                            inflight <= 1'b0;
                        end else begin
                            inflight <= 1'b1;
                        end
                    end
                end
                KILL: begin
                    if (redirect_valid) fetch_pc <= redirect_pc;
                    if (imem_ack) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Circular fetch queue; a redirect empties it regardless of push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= fetch_pc;
                q_instr[wr_ptr] <= imem_rdata;
                wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect/latency traffic.
// A program-order scoreboard predicts every consumed entry from the fetch rules.
// Memory responder is a simple latency model that returns an address-derived word.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic        ifid_pred_taken;

    int checks = 0;
    int failures = 0;
    int pops = 0;

`ifdef FETCH_BTFN_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    fetch_stage #(.PC_W(64), .RESET_PC(64'd0), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pred_taken(ifid_pred_taken)
    );

    always #5 clk = ~clk;

    // Program image: a backward beq at 0x40, elsewhere distinct non-branch words
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h40) return 32'hFE000EE3;
        return {a[21:2], 12'h013};
    endfunction

    function automatic logic exp_pred(input logic [63:0] pc);
        logic [31:0] w;
        w = mem_word(pc);
        return BTFN && (w[6:0] == 7'b1100011) && w[31];
    endfunction

    function automatic logic [63:0] exp_next(input logic [63:0] pc);
        logic [31:0] w;
        logic [63:0] off;
        w   = mem_word(pc);
        off = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (exp_pred(pc)) return pc + off;
        return pc + 64'd4;
    endfunction

    // Memory: ack once the request has been held eff_lat cycles (1 = same cycle)
    int fixed_lat = 1;
    int rnd_lat = 1;
    int wait_cnt;
    bit rand_mode = 1'b0;

    always_comb begin
        imem_ack   = imem_req && (wait_cnt >= ((rand_mode ? rnd_lat : fixed_lat) - 1));
        imem_rdata = mem_word(imem_addr);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (imem_req && !imem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
            if (imem_ack) rnd_lat <= $urandom_range(1, 4);
        end
    end

    // Scoreboard: consumed entries follow program order from the last reset/redirect
    logic [63:0] exp_pc;
    logic [63:0] prev_addr;
    bit          prev_pending;
    bit          red_prev;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc       = 64'h0;
            prev_pending = 1'b0;
            red_prev     = 1'b0;
        end else begin
            if (prev_pending) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL req_hold req=%0b addr=%h required req=1 addr=%h", imem_req, imem_addr, prev_addr);
                end
            end
            if (red_prev) begin
                checks++;
                if (ifid_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_after_redirect ifid_valid=%0b required 0", ifid_valid);
                end
            end
            if (ifid_valid === 1'b1 && !stall) begin
                checks++;
                if (ifid_pc !== exp_pc || ifid_instr !== mem_word(exp_pc) || ifid_pred_taken !== exp_pred(exp_pc)) begin
                    failures++;
                    $display("FAIL sb_pop pc=%h instr=%h pred=%0b required pc=%h instr=%h pred=%0b",
                             ifid_pc, ifid_instr, ifid_pred_taken, exp_pc, mem_word(exp_pc), exp_pred(exp_pc));
                end
                exp_pc = exp_next(exp_pc);
                pops++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            red_prev     = redirect_valid;
        end
    end

    task automatic do_reset(input int lat);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; rand_mode = 1'b0; fixed_lat = lat;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; fixed_lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", ifid_instr); end
        checks++; if (ifid_pc !== 64'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", ifid_pc); end
        checks++; if (ifid_pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred got=%0b exp=0", ifid_pred_taken); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%0b exp=0", imem_req); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'(4 * k)) begin
                failures++; $display("FAIL zw_addr k=%0d req=%0b addr=%h exp_addr=%h", k, imem_req, imem_addr, 64'(4 * k));
            end
            checks++;
            if (ifid_valid !== (k > 0)) begin
                failures++; $display("FAIL zw_valid k=%0d got=%0b exp=%0b", k, ifid_valid, (k > 0));
            end
            if (k > 0) begin
                checks++;
                if (ifid_pc !== 64'(4 * (k - 1))) begin
                    failures++; $display("FAIL zw_pc k=%0d got=%h exp=%h", k, ifid_pc, 64'(4 * (k - 1)));
                end
            end
        end
    endtask

    task automatic test_latency3();
        do_reset(3);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'(4 * (j / 3))) begin
                failures++; $display("FAIL lat3_addr j=%0d req=%0b addr=%h exp=%h", j, imem_req, imem_addr, 64'(4 * (j / 3)));
            end
            checks++;
            if (ifid_valid !== (j > 0 && j % 3 == 0)) begin
                failures++; $display("FAIL lat3_valid j=%0d got=%0b exp=%0b", j, ifid_valid, (j > 0 && j % 3 == 0));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1);
        stall = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                checks++;
                if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 64'h0) begin
                    failures++; $display("FAIL stall_full j=%0d req=%0b valid=%0b pc=%h exp req=0 valid=1 pc=0", j, imem_req, ifid_valid, ifid_pc);
                end
            end
        end
        @(posedge clk); #1 stall = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 64'(4 * j)) begin
                failures++; $display("FAIL stall_resume j=%0d valid=%0b pc=%h exp pc=%h", j, ifid_valid, ifid_pc, 64'(4 * j));
            end
        end
    endtask

    task automatic test_redirect_kill();
        bit found = 1'b0;
        do_reset(3);
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (imem_req && imem_ack && imem_addr == 64'h1C) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL kill_timeout got=no_ack_at_1C exp=ack_within_100");
        end else begin
            @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 64'h100;
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h20 || imem_ack !== 1'b0) begin
                failures++; $display("FAIL kill_pre req=%0b addr=%h ack=%0b exp 1/20/0", imem_req, imem_addr, imem_ack);
            end
            @(posedge clk); #1 redirect_valid = 1'b0;
            for (int t = 1; t <= 6; t++) begin
                if (t > 1) @(negedge clk);
                else @(negedge clk);
                checks++;
                if (t <= 5 && (imem_req !== 1'b1 || imem_addr !== ((t <= 2) ? 64'h20 : 64'h100) || ifid_valid !== 1'b0)) begin
                    failures++; $display("FAIL kill_seq t=%0d req=%0b addr=%h valid=%0b exp addr=%h valid=0",
                                         t, imem_req, imem_addr, ifid_valid, (t <= 2) ? 64'h20 : 64'h100);
                end else if (t == 6 && (ifid_valid !== 1'b1 || ifid_pc !== 64'h100)) begin
                    failures++; $display("FAIL kill_target valid=%0b pc=%h exp valid=1 pc=100", ifid_valid, ifid_pc);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || ifid_valid !== 1'b0) begin
            failures++; $display("FAIL wrap_first addr=%h valid=%0b exp addr=fffffffffffffffc valid=0", imem_addr, ifid_valid);
        end
        @(negedge clk);
        checks++;
        if (imem_addr !== 64'h0 || ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++; $display("FAIL wrap_next addr=%h pc=%h exp addr=0 pc=fffffffffffffffc", imem_addr, ifid_pc);
        end
    endtask

    task automatic test_btfn();
        logic [63:0] exp_addr;
        exp_addr = BTFN ? 64'h3C : 64'h44;
        do_reset(1);
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 64'h40;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_addr !== 64'h40) begin failures++; $display("FAIL btfn_addr0 got=%h exp=40", imem_addr); end
        @(negedge clk);
        checks++;
        if (imem_addr !== exp_addr) begin failures++; $display("FAIL btfn_next got=%h exp=%h", imem_addr, exp_addr); end
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 64'h40 || ifid_instr !== 32'hFE000EE3 || ifid_pred_taken !== BTFN) begin
            failures++; $display("FAIL btfn_head valid=%0b pc=%h instr=%h pred=%0b exp 1/40/fe000ee3/%0b",
                                 ifid_valid, ifid_pc, ifid_instr, ifid_pred_taken, BTFN);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (ifid_valid !== 1'b1 || imem_req !== 1'b1) begin
            failures++; $display("FAIL mid_pre valid=%0b req=%0b exp 1/1", ifid_valid, imem_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 64'h0 || ifid_pc !== 64'h0) begin
            failures++; $display("FAIL mid_rst req=%0b valid=%0b addr=%h pc=%h exp all 0", imem_req, ifid_valid, imem_addr, ifid_pc);
        end
    endtask

    task automatic test_random();
        int p0;
        do_reset(1);
        rand_mode = 1'b1;
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 64'($urandom_range(0, 40)) << 2;
        end
        @(posedge clk); #1 stall = 1'b0; redirect_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (pops - p0 < 200) begin
            failures++; $display("FAIL rand_progress pops=%0d exp>=200", pops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_latency3();
        test_stall();
        test_redirect_kill();
        test_wrap();
        test_btfn();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
